// File: rtl/id_inst_queue_pkg.sv
// Shared defaults and the {pc, inst} entry packing used by the IF/ID instruction queue.
`timescale 1ns/1ps

`ifndef IQ_PACK
`define IQ_PACK(pc, inst) {(pc), (inst)}
`endif

package id_inst_queue_pkg;

  localparam int unsigned IQ_DEPTH    = 4;
  localparam int unsigned IQ_PC_W     = 32;
  localparam int unsigned IQ_INST_W   = 32;
  localparam int unsigned IQ_ENTRY_WD = IQ_PC_W + IQ_INST_W;

endpackage

// File: rtl/iq_ring_ctrl.sv
// Ring pointers, occupancy and fetch credit for the instruction queue.
`timescale 1ns/1ps

module iq_ring_ctrl
  import id_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             fetch_req_i,
  input  logic             inflight_v_i,
  input  logic             out_ready_i,
  output logic             fetch_allow_o,
  output logic             req_fire_o,
  output logic             out_valid_o,
  output logic             enq_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   credit_use;
  logic             enq, deq;

  assign enq = inflight_v_i & ~flush_i;
  assign deq = (count_q != '0) & out_ready_i & ~flush_i;

  // Credit counts the in-flight read as occupied so its response always has a slot.
  assign credit_use    = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_v_i};
  assign fetch_allow_o = ~flush_i & (credit_use < (CNT_W + 1)'(DEPTH));
  assign req_fire_o    = fetch_req_i & fetch_allow_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid_o = (count_q != '0);
  assign enq_o       = enq;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;

  a_no_enq_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(enq && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/id_inst_queue.sv
// IF->ID decoupling queue: credit-gated fetch, one-deep in-flight tracker, DEPTH-entry {pc, inst} FIFO.
`timescale 1ns/1ps

module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = IQ_DEPTH,
  parameter int unsigned PC_W   = IQ_PC_W,
  parameter int unsigned INST_W = IQ_INST_W,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              fetch_allow,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = PC_W + INST_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic               inflight_v_q;
  logic [PC_W-1:0]    inflight_pc_q;
  logic               req_fire, enq;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  iq_ring_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk_i         (clk),
    .rst_ni        (rst),
    .flush_i       (flush),
    .fetch_req_i   (fetch_req),
    .inflight_v_i  (inflight_v_q),
    .out_ready_i   (out_ready),
    .fetch_allow_o (fetch_allow),
    .req_fire_o    (req_fire),
    .out_valid_o   (out_valid),
    .enq_o         (enq),
    .wr_ptr_o      (wr_ptr),
    .rd_ptr_o      (rd_ptr),
    .count_o       (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_v_q <= req_fire;
      if (req_fire) inflight_pc_q <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr] <= `IQ_PACK(inflight_pc_q, inst_sram_rdata);
  end

  assign head     = mem_q[rd_ptr];
  assign out_pc   = out_valid ? head[ENTRY_W-1 -: PC_W] : '0;
  assign out_inst = out_valid ? head[INST_W-1:0]        : '0;

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue with a 1-cycle SRAM model and a FIFO-order scoreboard.
`timescale 1ns/1ps

module tb_id_inst_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam logic [31:0] KEY    = 32'h83C1_1234;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              fetch_req;
  logic [PC_W-1:0]   fetch_pc;
  logic              fetch_allow;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  int checks   = 0;
  int failures = 0;

  id_inst_queue #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .fetch_req       (fetch_req),
    .fetch_pc        (fetch_pc),
    .fetch_allow     (fetch_allow),
    .inst_sram_rdata (inst_sram_rdata),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_ready       (out_ready),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: answers an issued read one cycle later with pc ^ KEY, garbage otherwise.
  logic        issued_q;
  logic [31:0] issued_pc_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q    <= 1'b0;
      issued_pc_q <= '0;
    end else begin
      issued_q    <= fetch_req & fetch_allow & ~flush;
      issued_pc_q <= fetch_pc;
    end
  end
  assign inst_sram_rdata = issued_q ? (issued_pc_q ^ KEY) : 32'hDEAD_BEEF;

  logic ovf_seen = 1'b0;
  always @(posedge clk) begin
    if (rst && issued_q && !flush && count == CNT_W'(DEPTH)) ovf_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n_iss;
    int n_out;
    int cyc;

    rst = 1'b0; flush = 1'b0; fetch_req = 1'b0; fetch_pc = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_allow", fetch_allow, 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);

    // single fetch, no bypass
    tick();
    fetch_req = 1'b1; fetch_pc = 32'hBFC0_0000;
    #1 chk("single_allow", fetch_allow, 1);
    tick();
    fetch_req = 1'b0;
    #1 chk("single_nobypass", out_valid, 0);
    tick();
    #1;
    chk("single_valid", out_valid, 1);
    chk("single_pc", out_pc, 32'hBFC0_0000);
    chk("single_inst", out_inst, 32'h3C01_1234);
    chk("single_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1 chk("single_drained", count, 0);

    // fill with out_ready low
    fetch_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fetch_pc = 32'h100 + 32'(4 * k);
      tick();
    end
    fetch_pc = 32'h110;
    #1;
    chk("fill_allow_drop", fetch_allow, 0);
    chk("fill_count3", count, 3);
    tick();
    #1;
    chk("fill_count4", count, 4);
    chk("fill_allow_full", fetch_allow, 0);
    repeat (3) tick();
    #1 chk("fill_hold4", count, 4);
    fetch_req = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      #1;
      chk("fill_drain_pc", out_pc, 32'h100 + 32'(4 * d));
      chk("fill_drain_inst", out_inst, (32'h100 + 32'(4 * d)) ^ KEY);
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("fill_empty", count, 0);
    chk("fill_empty_valid", out_valid, 0);

    // flush with a read in flight and a same-cycle request
    fetch_req = 1'b1;
    fetch_pc = 32'h300; tick();
    fetch_pc = 32'h304; tick();
    fetch_pc = 32'h200; tick();
    flush = 1'b1; fetch_pc = 32'h500;
    #1;
    chk("flush_pre_count", count, 2);
    chk("flush_allow_low", fetch_allow, 0);
    tick();
    flush = 1'b0; fetch_pc = 32'h400;
    #1;
    chk("flush_count0", count, 0);
    chk("flush_valid0", out_valid, 0);
    chk("flush_allow_back", fetch_allow, 1);
    tick();
    fetch_req = 1'b0;
    #1 chk("flush_resp_dropped", count, 0);
    tick();
    #1;
    chk("flush_next_count", count, 1);
    chk("flush_next_pc", out_pc, 32'h400);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1 chk("flush_next_drained", count, 0);

    // simultaneous enqueue and dequeue at count 3
    fetch_req = 1'b1;
    fetch_pc = 32'h600; tick();
    fetch_pc = 32'h604; tick();
    fetch_pc = 32'h608; tick();
    fetch_pc = 32'h60C;
    #1 chk("simul_pre_count", count, 2);
    tick();
    fetch_req = 1'b0; out_ready = 1'b1;
    #1;
    chk("simul_count3", count, 3);
    chk("simul_head0", out_pc, 32'h600);
    tick();
    #1;
    chk("simul_count_hold", count, 3);
    chk("simul_head1", out_pc, 32'h604);
    tick();
    #1;
    chk("simul_head2", out_pc, 32'h608);
    chk("simul_count2", count, 2);
    tick();
    #1;
    chk("simul_head3", out_pc, 32'h60C);
    chk("simul_inst3", out_inst, 32'h60C ^ KEY);
    tick();
    out_ready = 1'b0;
    #1 chk("simul_empty", count, 0);

    // asynchronous reset mid-stream at count 3
    fetch_req = 1'b1;
    fetch_pc = 32'h700; tick();
    fetch_pc = 32'h704; tick();
    fetch_pc = 32'h708; tick();
    fetch_req = 1'b0;
    tick();
    #1 chk("arst_pre_count", count, 3);
    #1 rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_allow", fetch_allow, 1);
    tick();
    rst = 1'b1;
    #1;

    // wrap-around stream with random back-pressure
    n_iss = 0; n_out = 0; cyc = 0;
    while (n_out < 12 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      fetch_req = (n_iss < 12);
      fetch_pc  = 32'h1000 + 32'(4 * n_iss);
      #1;
      if (out_valid && out_ready) begin
        chk("wrap_pc", out_pc, 32'h1000 + 32'(4 * n_out));
        chk("wrap_inst", out_inst, (32'h1000 + 32'(4 * n_out)) ^ KEY);
        n_out++;
      end
      if (fetch_req && fetch_allow) n_iss++;
      tick();
      cyc++;
    end
    out_ready = 1'b0; fetch_req = 1'b0;
    #1;
    chk("wrap_all_out", 64'(n_out), 12);
    chk("wrap_empty", count, 0);
    chk("no_enq_when_full", ovf_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised instruction decoupling queue between the IF stage and the ID stage of the 5-stage pipeline.
- Replaces the single held-instruction register in decode with a DEPTH-entry FIFO of {pc, inst} pairs.
- Credit-gates the fetch stage so a 1-cycle-latency inst SRAM response is never lost.
- Branch-taken flush discards queued entries and any in-flight response.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- PC_W, 32, PC width.
- INST_W, 32, instruction width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  branch taken (br_e from decode); discard everything this cycle.
- fetch_req  in  1  IF wants to issue an inst SRAM read this cycle.
- fetch_pc  in  PC_W  PC of that read.
- fetch_allow  out  1  credit; the read is issued only when fetch_req & fetch_allow.
- inst_sram_rdata  in  INST_W  SRAM data, valid the cycle after an issued read.
- out_valid  out  1  head entry valid.
- out_pc  out  PC_W  head entry PC.
- out_inst  out  INST_W  head entry instruction.
- out_ready  in  1  ID accepts the head (ID not stalled).
- count  out  CNT_W  queue occupancy.

Behaviour:
- Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, inflight_v=0, inflight_pc=0. Outputs: out_valid=0, out_pc=0, out_inst=0, fetch_allow=1, count=0. Release is synchronous to clk.
- req_fire = fetch_req & fetch_allow & ~flush.
- On req_fire: inflight_v<=1 and inflight_pc<=fetch_pc. Otherwise inflight_v<=0, so at most one read is in flight.
- Enqueue when inflight_v & ~flush:
  - mem[wr_ptr] <= {inflight_pc, inst_sram_rdata}
  - wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
- Latency: fetch_req at cycle T, SRAM data at T+1, entry written at the end of T+1, out_valid=1 at T+2. There is no bypass path.
- fetch_allow = ~flush & (count + inflight_v < DEPTH), computed combinationally from registered state. It does not look ahead to a same-cycle dequeue.
- The credit rule guarantees an enqueue never occurs at count==DEPTH. An assertion must check this.
- Head outputs:
  - out_valid = (count != 0).
  - out_pc and out_inst = mem[rd_ptr] when out_valid, else 0.
- Dequeue when out_valid & out_ready & ~flush: rd_ptr <= rd_ptr+1, wrapping.
- count update: count += enq − deq. Simultaneous enqueue and dequeue leaves count unchanged.
- Flush, taking priority over every other event in the same cycle:
  - rd_ptr, wr_ptr, count <= 0; inflight_v <= 0.
  - That cycle's fetch_req is not issued.
  - A response whose read was issued the cycle before the flush is discarded.
  - fetch_allow=1 again on the cycle after the flush.
- Ordering: strict FIFO across pointer wrap. PCs leave the queue in the order fetch_pc was issued.
- Storage is plain flops. mem contents are not reset and never observable when count==0.

Decomposition:
- Shared package / defines header:
  - IQ_DEPTH, PC_W, INST_W defaults.
  - IQ_ENTRY_WD = PC_W+INST_W.
  - Bus packing macro for {pc, inst} so ID unpacks consistently.
- One sub-module, iq_ring_ctrl: pointers, count and the credit equation. id_inst_queue wraps it with the storage array and the in-flight register.

Test Plan:
- Reset: assert rst=0 mid-stream with count=3 → count=0, out_valid=0, fetch_allow=1 immediately, without waiting for a clock edge.
- Single fetch: fetch_req at T with pc=0xBFC00000, rdata=0x3C011234 at T+1 → at T+2 out_valid=1, out_pc=0xBFC00000, out_inst=0x3C011234.
- Fill: out_ready=0, fetch_req held high with pc += 4 from 0x100 → fetch_allow drops once count+inflight=4. count reaches exactly 4 and holds, with entries 0x100..0x10C.
- Flush with in-flight: fetch issued at T (pc=0x200), flush=1 at T+1 with count=2 → count=0 at T+2, the 0x200 response is never enqueued, fetch_allow=1 at T+2.
- Simultaneous enqueue/dequeue at count=3, out_ready=1 → count stays 3, head advances by one entry, order preserved.
- Wrap-around: stream 12 sequential PCs with random out_ready → output PCs are exactly the issued sequence with no duplicates or gaps, and no enqueue ever occurs at count==DEPTH.
